// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until the
// owner drops its request or MAX_HOLD cycles elapse, then rotates priority past
// the previous owner. Grant is presented one-hot and as a binary index.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [HCW-1:0] hold_cnt, hold_cnt_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic           timeout_n;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] pick;
    logic           found;
    logic [IDW-1:0] ptr_after;

    // Rotating-priority search: first set request starting at ptr, wrapping mod N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Owner just past the current grant becomes highest priority after it ends.
    assign ptr_after = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

    // Next-state and registered-output logic; release beats timeout beats hold.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        gnt_n      = gnt;
        gnt_id_n   = gnt_id;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                gnt_n    = '0;
                gnt_id_n = '0;
                if (found) begin
                    state_n     = GRANT;
                    gnt_n[pick] = 1'b1;
                    gnt_id_n    = pick;
                    hold_cnt_n  = HCW'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_n  = IDLE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    ptr_n    = ptr_after;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD))) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    gnt_id_n  = '0;
                    ptr_n     = ptr_after;
                    timeout_n = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
            end
        endcase
    end

    // State and output registers; reset overrides any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            timeout  <= timeout_n;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against an integer-level model of the ownership rules.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner index (-1 when idle), cycles owned, priority pointer, timeout flag.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b0;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b1;
        end else begin
            m_held++; m_to = 1'b0;
        end
    endtask

    // One clock: step model at the edge, compare all outputs shortly after.
    task automatic cycle();
        logic [N-1:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int order [5] = '{0, 1, 2, 3, 0};

        // 1. Reset held two cycles with all requests active.
        rst = 1'b1; req = 4'b1111;
        cycle(); cycle();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 2. Single request, grant then release.
        req = 4'b0100;
        cycle();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_id", 32'(gnt_id), 32'd2);
        req = 4'b0000;
        cycle();
        chk("t2_rel", 32'(gnt), 32'd0);
        req = 4'b1111;
        cycle();
        chk("t2_ptr3", 32'(gnt_id), 32'd3);
        req = 4'b0000;
        cycle();

        // 3. All requesting, each owner drops for one cycle after 3 grant cycles.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cycle();
            chk("t3_order", 32'(gnt_id), 32'(order[g]));
            chk("t3_busy", 32'(busy), 32'd1);
            cycle(); cycle();
            req[order[g]] = 1'b0;
            cycle();
            chk("t3_dead", 32'(gnt), 32'd0);
            req = 4'b1111;
        end
        req = 4'b0000;
        cycle(); cycle();

        // 4. Hold timeout with constant requests.
        do_reset();
        req = 4'b0011;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (gnt == 4'b0001) cnt++;
            else break;
        end
        chk("t4_len", 32'(cnt), 32'(MAX_HOLD));
        chk("t4_to", 32'(timeout), 32'd1);
        chk("t4_dead", 32'(gnt), 32'd0);
        cycle();
        chk("t4_next", 32'(gnt), 32'h2);
        chk("t4_to_clr", 32'(timeout), 32'd0);
        req = 4'b0000;
        cycle(); cycle();

        // 5. Pointer wraps from 3 to 0.
        do_reset();
        req = 4'b1000;
        cycle();
        chk("t5_g3", 32'(gnt_id), 32'd3);
        req = 4'b0000;
        cycle();
        req = 4'b1001;
        cycle();
        chk("t5_wrap", 32'(gnt), 32'h1);
        chk("t5_id", 32'(gnt_id), 32'd0);
        req = 4'b0000;
        cycle();

        // 6. Reset during an active grant.
        do_reset();
        req = 4'b0100;
        cycle(); cycle();
        chk("t6_g2", 32'(gnt_id), 32'd2);
        rst = 1'b1;
        cycle();
        chk("t6_rst", 32'(gnt), 32'd0);
        rst = 1'b0;
        req = 4'b0101;
        cycle();
        chk("t6_after", 32'(gnt), 32'h1);

        // Randomized traffic: requests mostly persist, occasional reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
